fclass_wb_buf: RTL and testbench
================================

// Module: fclass_wb_buf
// PURPOSE
//  Writeback buffer directly downstream of the single-precision FCLASS unit.
//  Captures each 10-bit class mask with its destination register index in a small FIFO.
//  Zero-extends the mask to XLEN and presents it to the integer register-file write port
//  over a valid/ready handshake. Flags any mask that is not one-hot.
// PARAMETERS
//  XLEN   32  integer result width; mask occupies bits [9:0], bits [XLEN-1:10] are zero
//  DEPTH  4   FIFO entries; power of two, >= 2
//  AW     $clog2(DEPTH)  pointer width (localparam, not overridable)
// PORTS
//  clk        in   1     sole clock, rising edge
//  rst        in   1     asynchronous, active-high reset
//  flush      in   1     synchronous discard of all buffered entries
//  in_valid   in   1     upstream mask valid
//  in_ready   out  1     buffer can accept (= !full)
//  in_mask    in   10    class mask from FCLASS (bit0 -inf ... bit9 qNaN)
//  in_rd      in   5     destination register index
//  out_valid  out  1     head entry valid (= count != 0)
//  out_ready  in   1     register file accepts head
//  out_data   out  XLEN  zero-extended mask of head entry
//  out_rd     out  5     destination index of head entry
//  count      out  AW+1  number of occupied entries, 0..DEPTH
//  err_onehot out  1     sticky: some accepted mask was not exactly one-hot
// BEHAVIOUR
//  - Reset (async assert): wr_ptr=rd_ptr=0, count=0, out_valid=0, in_ready=1, err_onehot=0.
//    out_data/out_rd read 0 while empty. Storage array is not reset.
//  - Push when in_valid&&in_ready; pop when out_valid&&out_ready. Both evaluated each edge.
//  - Latency: a mask pushed at edge N is visible on out_* after edge N; no same-cycle bypass.
//  - Full (count==DEPTH): in_ready=0; a pop in that cycle does not re-open in_ready
//    until the next cycle (no pop-through).
//  - Empty: out_valid=0; out_ready is ignored; out_data=0, out_rd=0.
//  - Simultaneous push and pop with 0<count<DEPTH: count unchanged, both pointers advance.
//  - Pointers wrap modulo DEPTH; count saturates by construction at DEPTH.
//  - flush: pointers and count -> 0 at the next edge. Flush wins over a same-cycle push
//    and pop; the flushed push is dropped. err_onehot is not cleared by flush.
//  - err_onehot sets on any accepted push whose in_mask has popcount != 1.
//    The entry is still buffered and delivered unchanged. Only rst clears err_onehot.
//  - out_* are stable while out_valid && !out_ready (AXI-style hold).
//  - Reset asserted mid-transfer discards all entries immediately (async).
// CONFIGURATION
//  FCLASS_STATS_EN defined: adds outputs stat_nan[15:0] and stat_inf[15:0].
//  - stat_nan counts accepted pushes with mask[9]|mask[8]; stat_inf counts mask[7]|mask[0].
//  - Both are saturating at 16'hFFFF, reset to 0 by rst only, unaffected by flush.
//  FCLASS_STATS_EN undefined: those ports and counters do not exist; all else identical.
// STRUCTURE
//  - Shared package fclass_pkg: CLASS_W=10, bit-index constants CLS_NINF..CLS_QNAN (0..9),
//    and function is_onehot10().
//  - One sub-module: fclass_fifo (generic DEPTH x W register FIFO with count, flush),
//    instantiated with W=15 {rd,mask}.
//  - Top level holds zero-extension, one-hot checker and optional stats.
// TESTING
//  1. Reset, push mask 10'h040 rd=3 -> next cycle out_valid=1, out_data=32'h40, out_rd=3, count=1.
//  2. Push 4 masks with out_ready=0 -> count=4, in_ready=0; 5th push is held.
//     Raise out_ready -> pops in FIFO order, in_ready returns the cycle after the first pop.
//  3. count=2, push and pop same cycle -> count stays 2; order preserved across pointer wrap
//     (run 10 entries).
//  4. Push 10'h003 -> err_onehot=1 and data 32'h3 delivered.
//     flush -> count=0, err_onehot still 1. rst -> err_onehot=0.
//  5. flush with in_valid=1 same cycle -> count=0 next cycle; that entry never appears on out_*.
//  6. With FCLASS_STATS_EN: push 10'h200, 10'h100, 10'h080 -> stat_nan=2, stat_inf=1.
//     Force 65536 NaN pushes -> stat_nan holds 16'hFFFF.

Source files
------------

// File: rtl/fclass_pkg.sv
// Shared definitions for the FCLASS writeback path: class-mask width, class
// bit positions, FIFO entry layout and a one-hot check helper.
package fclass_pkg;

  localparam int unsigned CLASS_W = 10;
  localparam int unsigned RD_W    = 5;
  localparam int unsigned ENTRY_W = CLASS_W + RD_W;
  localparam int unsigned STAT_W  = 16;

  // Bit positions within the FCLASS result mask
  localparam int unsigned CLS_NINF  = 0;
  localparam int unsigned CLS_NNORM = 1;
  localparam int unsigned CLS_NSUB  = 2;
  localparam int unsigned CLS_NZERO = 3;
  localparam int unsigned CLS_PZERO = 4;
  localparam int unsigned CLS_PSUB  = 5;
  localparam int unsigned CLS_PNORM = 6;
  localparam int unsigned CLS_PINF  = 7;
  localparam int unsigned CLS_SNAN  = 8;
  localparam int unsigned CLS_QNAN  = 9;

  // One buffered writeback: destination index above the class mask
  typedef struct packed {
    logic [RD_W-1:0]    rd;
    logic [CLASS_W-1:0] mask;
  } wb_entry_t;

  // True when exactly one bit of the mask is set
  function automatic logic is_onehot10(input logic [CLASS_W-1:0] m);
    return (m != '0) && ((m & (m - CLASS_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/fclass_fifo.sv
// Generic DEPTH x W register FIFO with occupancy count and synchronous flush.
// Ports: clk, rst (async, active-high), flush; write side wr_valid/wr_ready/
// wr_data; read side rd_valid/rd_ready/rd_data (reads 0 while empty); count.
// Full blocks writes even if a read happens in the same cycle. Flush discards
// everything and overrides any same-cycle read or write.
module fclass_fifo #(
  parameter  int unsigned W     = 15,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [W-1:0]  wr_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [W-1:0]  rd_data,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push, pop;

  assign wr_ready = (count_q != FULL);
  assign rd_valid = (count_q != '0);
  assign push     = wr_valid && wr_ready && !flush;
  assign pop      = rd_valid && rd_ready && !flush;
  assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign count    = count_q;

  // Pointer/count update; DEPTH is a power of two so pointers wrap naturally
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is intentionally left unreset; rd_data is gated while empty
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/fclass_wb_buf.sv
// Writeback buffer after the single-precision FCLASS unit. Queues class masks
// with their destination register, zero-extends the head mask to XLEN for the
// integer register file, and keeps a sticky flag for non-one-hot masks.
// Ports: clk, rst (async, active-high), flush; in_valid/in_ready/in_mask/in_rd;
// out_valid/out_ready/out_data/out_rd; count; err_onehot.
// Optional macro FCLASS_STATS_EN adds saturating counters stat_nan/stat_inf.
module fclass_wb_buf
  import fclass_pkg::*;
#(
  parameter  int unsigned XLEN  = 32,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CLASS_W-1:0] in_mask,
  input  logic [RD_W-1:0]    in_rd,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_data,
  output logic [RD_W-1:0]    out_rd,
  output logic [AW:0]        count,
  output logic               err_onehot
`ifdef FCLASS_STATS_EN
  ,
  output logic [STAT_W-1:0]  stat_nan,
  output logic [STAT_W-1:0]  stat_inf
`endif
);

  wb_entry_t wr_entry, head;
  logic      accept;
  logic      err_onehot_q, err_onehot_d;

  assign wr_entry.rd   = in_rd;
  assign wr_entry.mask = in_mask;

  fclass_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .wr_valid (in_valid),
    .wr_ready (in_ready),
    .wr_data  (wr_entry),
    .rd_valid (out_valid),
    .rd_ready (out_ready),
    .rd_data  (head),
    .count    (count)
  );

  // Head reads as zero while empty, so the extension is zero too
  assign out_data = XLEN'(head.mask);
  assign out_rd   = head.rd;

  // A push dropped by flush is not treated as accepted
  assign accept = in_valid && in_ready && !flush;

  always_comb begin
    err_onehot_d = err_onehot_q;
    if (accept && !is_onehot10(in_mask)) err_onehot_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_onehot_q <= 1'b0;
    else     err_onehot_q <= err_onehot_d;
  end

  assign err_onehot = err_onehot_q;

`ifdef FCLASS_STATS_EN
  logic [STAT_W-1:0] stat_nan_q, stat_nan_d;
  logic [STAT_W-1:0] stat_inf_q, stat_inf_d;

  // Saturating class counters; flush does not touch them
  always_comb begin
    stat_nan_d = stat_nan_q;
    stat_inf_d = stat_inf_q;
    if (accept && (in_mask[CLS_QNAN] || in_mask[CLS_SNAN]) && (stat_nan_q != '1))
      stat_nan_d = stat_nan_q + STAT_W'(1);
    if (accept && (in_mask[CLS_PINF] || in_mask[CLS_NINF]) && (stat_inf_q != '1))
      stat_inf_d = stat_inf_q + STAT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_nan_q <= '0;
      stat_inf_q <= '0;
    end else begin
      stat_nan_q <= stat_nan_d;
      stat_inf_q <= stat_inf_d;
    end
  end

  assign stat_nan = stat_nan_q;
  assign stat_inf = stat_inf_q;
`endif

endmodule

// File: tb/tb_fclass_wb_buf.sv
// Scoreboard bench for fclass_wb_buf: stimulus pushes expected writebacks into
// a queue, a negedge monitor pops and compares whenever the DUT pops.
module tb_fclass_wb_buf;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  in_mask;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic [2:0]  count;
  logic        err_onehot;
`ifdef FCLASS_STATS_EN
  logic [15:0] stat_nan;
  logic [15:0] stat_inf;
`endif

  fclass_wb_buf #(.XLEN(32), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mask    (in_mask),
    .in_rd      (in_rd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_rd     (out_rd),
    .count      (count),
    .err_onehot (err_onehot)
`ifdef FCLASS_STATS_EN
    ,
    .stat_nan   (stat_nan),
    .stat_inf   (stat_inf)
`endif
  );

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic        stall_q = 1'b0;
  logic [31:0] hold_data;
  logic [4:0]  hold_rd;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares popped heads against the scoreboard and checks hold
  always @(negedge clk) begin
    if (rst || flush) begin
      sb.delete();
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        n_tests++;
        if (out_data !== hold_data || out_rd !== hold_rd) begin
          n_fail++;
          $display("FAIL hold: got %h/%0d, expected %h/%0d", out_data, out_rd, hold_data, hold_rd);
        end
      end
      if (out_valid && out_ready) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_pop: got %h/%0d, expected no entry", out_data, out_rd);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (out_data !== e.data || out_rd !== e.rd) begin
            n_fail++;
            $display("FAIL pop_data: got %h/%0d, expected %h/%0d", out_data, out_rd, e.data, e.rd);
          end
        end
      end
      stall_q   = out_valid && !out_ready;
      hold_data = out_data;
      hold_rd   = out_rd;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic push(input logic [9:0] m, input logic [4:0] r);
    bit done;
    exp_t e;
    done     = 1'b0;
    in_valid = 1'b1;
    in_mask  = m;
    in_rd    = r;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready && !flush && !rst) begin
        e.data = {22'd0, m};
        e.rd   = r;
        sb.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL push_timeout: got in_ready=0, expected acceptance of %h", m);
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (count == 3'd0) break;
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("drain_count", 32'(count), 32'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_mask = '0; in_rd = '0; out_ready = 1'b0;
    @(posedge clk); #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_err", 32'(err_onehot), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_rd", 32'(out_rd), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: latency, no bypass
    in_valid = 1'b1; in_mask = 10'h040; in_rd = 5'd3;
    @(negedge clk);
    check("no_bypass", 32'(out_valid), 32'd0);
    sb.push_back('{data: 32'h40, rd: 5'd3});
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_data", out_data, 32'h40);
    check("t1_rd", 32'(out_rd), 32'd3);
    check("t1_count", 32'(count), 32'd1);
    drain();

    // 2: fill, hold 5th push, no pop-through
    push(10'h001, 5'd1);
    push(10'h002, 5'd2);
    push(10'h004, 5'd4);
    push(10'h008, 5'd8);
    check("full_count", 32'(count), 32'd4);
    check("full_in_ready", 32'(in_ready), 32'd0);
    fork
      push(10'h010, 5'd16);
      begin
        @(negedge clk);
        @(negedge clk);
        check("held_count", 32'(count), 32'd4);
        check("held_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("no_pop_through", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("reopen", 32'(in_ready), 32'd1);
      end
    join
    check("t2_count", 32'(count), 32'd3);
    drain();

    // 3: simultaneous push/pop at count 2 across pointer wrap
    push(10'h100, 5'd20);
    push(10'h200, 5'd21);
    check("t3_count2", 32'(count), 32'd2);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      logic [9:0] m;
      m = 10'd1 << i;
      push(m, 5'(i + 10));
    end
    check("t3_pp_count", 32'(count), 32'd2);
    drain();

    // 4: non-one-hot mask, flush keeps err, rst clears it
    push(10'h003, 5'd7);
    check("err_set", 32'(err_onehot), 32'd1);
    drain();
    push(10'h020, 5'd1);
    push(10'h001, 5'd2);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_count", 32'(count), 32'd0);
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_err", 32'(err_onehot), 32'd1);
    push(10'h004, 5'd4);
    rst = 1'b1;
    #1;
    check("async_rst_count", 32'(count), 32'd0);
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_err", 32'(err_onehot), 32'd0);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // 5: flush wins over same-cycle push
    flush = 1'b1; in_valid = 1'b1; in_mask = 10'h080; in_rd = 5'd6;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("t5_count", 32'(count), 32'd0);
    check("t5_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b0;

`ifdef FCLASS_STATS_EN
    // 6: stats counting and saturation
    check("stat_nan_rst", 32'(stat_nan), 32'd0);
    out_ready = 1'b1;
    push(10'h200, 5'd1);
    push(10'h100, 5'd2);
    push(10'h080, 5'd3);
    check("stat_nan", 32'(stat_nan), 32'd2);
    check("stat_inf", 32'(stat_inf), 32'd1);
    for (int i = 0; i < 65536; i++) push(10'h200, 5'd9);
    check("stat_nan_sat", 32'(stat_nan), 32'hFFFF);
    check("stat_inf_keep", 32'(stat_inf), 32'd1);
    drain();
`endif

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
